rvlab_tlul_host_mux: RTL and testbench

Two-host to one-device TL-UL multiplexer placed directly downstream of the CPU's instruction and data TL-UL ports. It merges both ports onto a single TL-UL host port towards the crossbar or memory. It tags each request's source ID with the originating host and routes responses back by that tag. It also tracks outstanding transactions per host and holds the arbitration decision while a request is stalled.

---
 rtl/rvlab_host_mux_pkg.sv | 49 ++++
 rtl/rvlab_rr_arb2.sv | 61 ++++++
 rtl/rvlab_tlul_host_mux.sv | 89 ++++++++
 tb/tb_rvlab_tlul_host_mux.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvlab_host_mux_pkg.sv
// Shared types for the two-host TL-UL multiplexer: TL-UL channel structs,
// host indices and counter sizing.
package rvlab_host_mux_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef enum logic {
    HOST_I = 1'b0,
    HOST_D = 1'b1
  } host_idx_e;

  // MSB of the source ID carries the originating host on the merged port.
  localparam int SrcTagBit = TL_AIW - 1;
  localparam int OutCntW   = 4;

  function automatic host_idx_e other_host(input host_idx_e h);
    return (h == HOST_I) ? HOST_D : HOST_I;
  endfunction

endpackage

// File: rtl/rvlab_rr_arb2.sv
// Two-way arbiter with a hold-while-stalled lock. Round-robin by default;
// RVLAB_HOST_MUX_DPRIO_EN selects fixed priority for HOST_D instead.
module rvlab_rr_arb2
  import rvlab_host_mux_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic [1:0] req,
  input  logic      ready,
  output logic      gnt_valid,
  output host_idx_e gnt_host
);

  logic      lock_q;
  host_idx_e lock_host_q;
  logic      lock_active;

  // A host that drops its request releases the lock rather than starving the other.
  assign lock_active = lock_q && req[lock_host_q];
  assign gnt_valid   = |req;

`ifndef RVLAB_HOST_MUX_DPRIO_EN
  host_idx_e rr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= HOST_I;
    end else if (gnt_valid && ready) begin
      rr_ptr_q <= other_host(gnt_host);
    end
  end
`endif

  // NOTE: every path assigns gnt_host, starting from a default, so no latch is inferred.
  always_comb begin
    gnt_host = HOST_I;
    if (lock_active) begin
      gnt_host = lock_host_q;
    end else if (req == 2'b11) begin
`ifdef RVLAB_HOST_MUX_DPRIO_EN
      gnt_host = HOST_D;
`else
      gnt_host = rr_ptr_q;
`endif
    end else if (req[HOST_D]) begin
      gnt_host = HOST_D;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q      <= 1'b0;
      lock_host_q <= HOST_I;
    end else begin
      lock_q      <= gnt_valid && !ready;
      lock_host_q <= gnt_host;
    end
  end

endmodule

// File: rtl/rvlab_tlul_host_mux.sv
// Merges the CPU instruction and data TL-UL ports onto one device port,
// tagging source IDs by host and routing responses back by that tag.
// Optional build macro: RVLAB_HOST_MUX_DPRIO_EN (data host fixed priority).
module rvlab_tlul_host_mux
  import rvlab_host_mux_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_i_i,
  output tl_d2h_t tl_i_o,
  input  tl_h2d_t tl_d_i,
  output tl_d2h_t tl_d_o,
  output tl_h2d_t tl_dev_o,
  input  tl_d2h_t tl_dev_i,
  output logic    err_o
);

  localparam logic [OutCntW-1:0] MaxOut = OutCntW'(MAX_OUTSTANDING);

  tl_h2d_t            host_req [2];
  tl_d2h_t            host_rsp [2];
  logic [OutCntW-1:0] out_cnt_q [2];
  logic [1:0]         eligible, tag_err, unsolicited, a_hs, d_hs;
  logic               gnt_valid;
  host_idx_e          gnt_host, rsp_host;

  assign host_req[HOST_I] = tl_i_i;
  assign host_req[HOST_D] = tl_d_i;
  assign tl_i_o           = host_rsp[HOST_I];
  assign tl_d_o           = host_rsp[HOST_D];
  assign rsp_host         = host_idx_e'(tl_dev_i.d_source[SrcTagBit]);

  always_comb begin
    for (int h = 0; h < 2; h++) begin
      eligible[h]    = host_req[h].a_valid && (out_cnt_q[h] < MaxOut);
      tag_err[h]     = host_req[h].a_valid && host_req[h].a_source[SrcTagBit];
      unsolicited[h] = (out_cnt_q[h] == '0);
    end
  end

  rvlab_rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req       (eligible),
    .ready     (tl_dev_i.a_ready),
    .gnt_valid (gnt_valid),
    .gnt_host  (gnt_host)
  );

  // Valid/ready are forced low during reset so no handshake can be counted.
  always_comb begin
    tl_dev_o                     = host_req[gnt_host];
    tl_dev_o.a_source[SrcTagBit] = gnt_host;
    tl_dev_o.a_valid             = gnt_valid && !rst_i;
    tl_dev_o.d_ready             = host_req[rsp_host].d_ready && !rst_i;
    for (int h = 0; h < 2; h++) begin
      host_rsp[h]                     = tl_dev_i;
      host_rsp[h].d_source[SrcTagBit] = 1'b0;
      host_rsp[h].d_valid = tl_dev_i.d_valid && (rsp_host == host_idx_e'(h[0])) && !rst_i;
      host_rsp[h].a_ready = tl_dev_i.a_ready && gnt_valid &&
                            (gnt_host == host_idx_e'(h[0])) && !rst_i;
      a_hs[h] = tl_dev_o.a_valid && tl_dev_i.a_ready && (gnt_host == host_idx_e'(h[0]));
      d_hs[h] = host_rsp[h].d_valid && tl_dev_o.d_ready;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_q[HOST_I] <= '0;
      out_cnt_q[HOST_D] <= '0;
      err_o             <= 1'b0;
    end else begin
      for (int h = 0; h < 2; h++) begin
        unique case ({a_hs[h], d_hs[h]})
          2'b10:   out_cnt_q[h] <= out_cnt_q[h] + OutCntW'(1);
          // A response with nothing outstanding leaves the counter pinned at zero.
          2'b01:   if (!unsolicited[h]) out_cnt_q[h] <= out_cnt_q[h] - OutCntW'(1);
          default: ;
        endcase
      end
      if ((|tag_err) || (|(d_hs & unsolicited))) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rvlab_tlul_host_mux.sv
// Self-checking bench for rvlab_tlul_host_mux: a routing vector table plus
// scoreboarded sequences for arbitration, lock, stall-at-limit, errors and reset.
module tb_rvlab_tlul_host_mux;
  import rvlab_host_mux_pkg::*;

  logic    clk_i = 1'b0;
  logic    rst_i;
  tl_h2d_t tl_i_i, tl_d_i, tl_dev_o;
  tl_d2h_t tl_i_o, tl_d_o, tl_dev_i;
  logic    err_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [TL_AIW-1:0] src;
    logic [31:0]       addr;
  } a_exp_t;
  typedef struct packed {
    logic              host;
    logic [TL_AIW-1:0] src;
  } d_exp_t;
  a_exp_t a_q[$];
  d_exp_t d_q[$];

  typedef struct packed {
    logic       iv;   logic [7:0] isrc;
    logic       dv;   logic [7:0] dsrc;
    logic       ardy; logic       rv;   logic [7:0] rsrc;
    logic       irdy; logic       drdy;
    logic       e_av; logic [7:0] e_asrc;
    logic       e_iar; logic      e_dar;
    logic       e_idv; logic      e_ddv;
    logic       e_drdy; logic [7:0] e_rsrc;
  } vec_t;
  vec_t vec [10];

  always #5 clk_i = ~clk_i;

  rvlab_tlul_host_mux #(.MAX_OUTSTANDING(4)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tl_i_i   (tl_i_i),
    .tl_i_o   (tl_i_o),
    .tl_d_i   (tl_d_i),
    .tl_d_o   (tl_d_o),
    .tl_dev_o (tl_dev_o),
    .tl_dev_i (tl_dev_i),
    .err_o    (err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: handshake seen, expected none (scoreboard empty)", name);
  endtask

  task automatic idle();
    tl_i_i = '0;  tl_i_i.d_ready = 1'b1;
    tl_d_i = '0;  tl_d_i.d_ready = 1'b1;
    tl_dev_i = '0; tl_dev_i.a_ready = 1'b1;
  endtask

  task automatic req_a(input host_idx_e h, input logic [7:0] src, input logic [31:0] addr);
    tl_h2d_t r;
    r = '0;
    r.a_valid = 1'b1; r.a_opcode = 3'h4; r.a_size = 2'd2;
    r.a_source = src; r.a_address = addr; r.a_mask = '1; r.d_ready = 1'b1;
    if (h == HOST_I) tl_i_i = r; else tl_d_i = r;
  endtask

  // Device-side view of a request: tag bit replaced by the host index.
  task automatic expect_a(input host_idx_e h, input logic [7:0] src, input logic [31:0] addr);
    a_q.push_back('{src: {h, src[6:0]}, addr: addr});
  endtask

  task automatic rsp_d(input logic [7:0] src, input logic host, input logic [7:0] deliver_src);
    tl_dev_i.d_valid  = 1'b1;
    tl_dev_i.d_opcode = 3'h1;
    tl_dev_i.d_source = src;
    tl_dev_i.d_data   = {24'h0, src};
    d_q.push_back('{host: host, src: deliver_src});
  endtask

  task automatic monitor();
    a_exp_t ea;
    d_exp_t ed;
    if (tl_dev_o.a_valid && tl_dev_i.a_ready) begin
      if (a_q.size() == 0) fail("sb_a_extra");
      else begin
        ea = a_q.pop_front();
        check("sb_a_source", tl_dev_o.a_source, ea.src);
        check("sb_a_address", tl_dev_o.a_address, ea.addr);
      end
    end
    if (tl_i_o.d_valid && tl_i_i.d_ready) begin
      if (d_q.size() == 0) fail("sb_d_extra_i");
      else begin
        ed = d_q.pop_front();
        check("sb_d_host_i", 64'(HOST_I), ed.host);
        check("sb_d_source_i", tl_i_o.d_source, ed.src);
      end
    end
    if (tl_d_o.d_valid && tl_d_i.d_ready) begin
      if (d_q.size() == 0) fail("sb_d_extra_d");
      else begin
        ed = d_q.pop_front();
        check("sb_d_host_d", 64'(HOST_D), ed.host);
        check("sb_d_source_d", tl_d_o.d_source, ed.src);
      end
    end
  endtask

  // Called with inputs settled (posedge+2); returns at the next posedge+1.
  task automatic next();
    monitor();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    a_q.delete();
    d_q.delete();
  endtask

  task automatic drained(input string name);
    check({name, "_a_left"}, a_q.size(), 0);
    check({name, "_d_left"}, d_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0] = '{1'b0,8'h00,1'b0,8'h00,1'b1,1'b0,8'h00,1'b1,1'b1, 1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00};
    vec[1] = '{1'b1,8'h05,1'b0,8'h00,1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,8'h05,1'b1,1'b0,1'b0,1'b0,1'b1,8'h00};
    vec[2] = '{1'b0,8'h00,1'b1,8'h03,1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,8'h83,1'b0,1'b1,1'b0,1'b0,1'b1,8'h00};
    vec[3] = '{1'b1,8'h7F,1'b0,8'h00,1'b1,1'b1,8'h85,1'b1,1'b1, 1'b1,8'h7F,1'b1,1'b0,1'b0,1'b1,1'b1,8'h05};
    vec[4] = '{1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,8'h05,1'b0,1'b1, 1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b0,8'h05};
    vec[5] = '{1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,8'h7F,1'b1,1'b0, 1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,1'b1,8'h7F};
    vec[6] = '{1'b1,8'h10,1'b0,8'h00,1'b0,1'b0,8'h80,1'b1,1'b0, 1'b1,8'h10,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00};
    vec[7] = '{1'b1,8'h10,1'b1,8'h22,1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,8'h10,1'b1,1'b0,1'b0,1'b0,1'b1,8'h00};
    vec[8] = '{1'b1,8'h11,1'b1,8'h22,1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,8'hA2,1'b0,1'b1,1'b0,1'b0,1'b1,8'h00};
    vec[9] = '{1'b1,8'h11,1'b0,8'h00,1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,8'h11,1'b1,1'b0,1'b0,1'b0,1'b1,8'h00};

    do_reset();
    check("reset_err", err_o, 1'b0);

    // Routing table: tagging, ready gating, D steering, lock on stall.
    for (int i = 0; i < 10; i++) begin
      idle();
      tl_i_i.a_valid = vec[i].iv;  tl_i_i.a_source = vec[i].isrc;  tl_i_i.d_ready = vec[i].irdy;
      tl_d_i.a_valid = vec[i].dv;  tl_d_i.a_source = vec[i].dsrc;  tl_d_i.d_ready = vec[i].drdy;
      tl_dev_i.a_ready  = vec[i].ardy;
      tl_dev_i.d_valid  = vec[i].rv;
      tl_dev_i.d_source = vec[i].rsrc;
      #1;
      check($sformatf("vec%0d_dev_a_valid", i), tl_dev_o.a_valid, vec[i].e_av);
      if (vec[i].e_av) check($sformatf("vec%0d_dev_a_source", i), tl_dev_o.a_source, vec[i].e_asrc);
      check($sformatf("vec%0d_i_a_ready", i), tl_i_o.a_ready, vec[i].e_iar);
      check($sformatf("vec%0d_d_a_ready", i), tl_d_o.a_ready, vec[i].e_dar);
      check($sformatf("vec%0d_i_d_valid", i), tl_i_o.d_valid, vec[i].e_idv);
      check($sformatf("vec%0d_d_d_valid", i), tl_d_o.d_valid, vec[i].e_ddv);
      check($sformatf("vec%0d_dev_d_ready", i), tl_dev_o.d_ready, vec[i].e_drdy);
      check($sformatf("vec%0d_rsp_source", i), tl_i_o.d_source, vec[i].e_rsrc);
      @(posedge clk_i);
      #1;
    end

    // I-only reads, sources 0..2, then responses routed back to I only.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req_a(HOST_I, 8'(k), 32'h100 + 32'(k));
      expect_a(HOST_I, 8'(k), 32'h100 + 32'(k));
      #1;
      next();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      rsp_d(8'(k), HOST_I, 8'(k));
      #1;
      check("t1_d_port_quiet", tl_d_o.d_valid, 1'b0);
      next();
    end
    idle();
    #1;
    drained("t1");
    check("t1_err", err_o, 1'b0);
    next();

    // Both hosts requesting every cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_a(HOST_I, 8'h01, 32'h1000);
      req_a(HOST_D, 8'h02, 32'h2000);
`ifdef RVLAB_HOST_MUX_DPRIO_EN
      expect_a(HOST_D, 8'h02, 32'h2000);
`else
      if (k % 2 == 0) expect_a(HOST_I, 8'h01, 32'h1000);
      else            expect_a(HOST_D, 8'h02, 32'h2000);
`endif
      #1;
      next();
    end
    idle();
    #1;
    drained("t2");
    next();

    // D stalled for 5 cycles while I waits; request must stay stable.
    do_reset();
    req_a(HOST_I, 8'h03, 32'h300);
    expect_a(HOST_I, 8'h03, 32'h300);
    #1;
    next();
    req_a(HOST_I, 8'h03, 32'h300);
    req_a(HOST_D, 8'h04, 32'h400);
    tl_dev_i.a_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_stall_a_valid", tl_dev_o.a_valid, 1'b1);
      check("t3_stall_a_source", tl_dev_o.a_source, 8'h84);
      check("t3_stall_a_address", tl_dev_o.a_address, 32'h400);
      check("t3_stall_i_a_ready", tl_i_o.a_ready, 1'b0);
      next();
    end
    tl_dev_i.a_ready = 1'b1;
    expect_a(HOST_D, 8'h04, 32'h400);
    #1;
    check("t3_d_accept", tl_d_o.a_ready, 1'b1);
    next();
    tl_d_i.a_valid = 1'b0;
    expect_a(HOST_I, 8'h03, 32'h300);
    #1;
    check("t3_i_after_d", tl_i_o.a_ready, 1'b1);
    next();
    idle();
    #1;
    drained("t3");
    next();

    // Outstanding limit: 5th request waits for one response.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_a(HOST_I, 8'(k), 32'h400 + 32'(4 * k));
      expect_a(HOST_I, 8'(k), 32'h400 + 32'(4 * k));
      #1;
      next();
    end
    req_a(HOST_I, 8'h04, 32'h410);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_limit_a_ready", tl_i_o.a_ready, 1'b0);
      check("t4_limit_dev_valid", tl_dev_o.a_valid, 1'b0);
      next();
    end
    rsp_d(8'h00, HOST_I, 8'h00);
    #1;
    check("t4_same_cycle_a_ready", tl_i_o.a_ready, 1'b0);
    next();
    tl_dev_i.d_valid = 1'b0;
    expect_a(HOST_I, 8'h04, 32'h410);
    #1;
    check("t4_regranted", tl_i_o.a_ready, 1'b1);
    next();
    idle();
    #1;
    drained("t4");
    check("t4_err", err_o, 1'b0);
    next();

    // Unsolicited response to D, then a tagged request from I.
    do_reset();
    rsp_d(8'h80, HOST_D, 8'h00);
    #1;
    check("t5_err_before_edge", err_o, 1'b0);
    check("t5_i_quiet", tl_i_o.d_valid, 1'b0);
    next();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_err_sticky", err_o, 1'b1);
      next();
    end
    do_reset();
    #1;
    check("t5_err_cleared", err_o, 1'b0);
    req_a(HOST_I, 8'h81, 32'h500);
    expect_a(HOST_I, 8'h81, 32'h500);
    #1;
    next();
    idle();
    #1;
    check("t5_tag_err", err_o, 1'b1);
    drained("t5");
    next();

    // Reset with two requests outstanding.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req_a(HOST_I, 8'(k), 32'h600 + 32'(k));
      expect_a(HOST_I, 8'(k), 32'h600 + 32'(k));
      #1;
      next();
    end
    rst_i = 1'b1;
    req_a(HOST_I, 8'h02, 32'h602);
    tl_dev_i.d_valid  = 1'b1;
    tl_dev_i.d_source = 8'h00;
    #1;
    check("t6_rst_dev_a_valid", tl_dev_o.a_valid, 1'b0);
    check("t6_rst_i_a_ready", tl_i_o.a_ready, 1'b0);
    check("t6_rst_i_d_valid", tl_i_o.d_valid, 1'b0);
    check("t6_rst_dev_d_ready", tl_dev_o.d_ready, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    a_q.delete();
    d_q.delete();
    idle();
    rsp_d(8'h01, HOST_I, 8'h01);
    #1;
    check("t6_err_before", err_o, 1'b0);
    next();
    idle();
    #1;
    check("t6_late_rsp_err", err_o, 1'b1);
    next();
    for (int k = 0; k < 4; k++) begin
      req_a(HOST_I, 8'h10 + 8'(k), 32'h700 + 32'(k));
      expect_a(HOST_I, 8'h10 + 8'(k), 32'h700 + 32'(k));
      #1;
      check("t6_cnt_cleared_grant", tl_i_o.a_ready, 1'b1);
      next();
    end
    req_a(HOST_I, 8'h14, 32'h704);
    #1;
    check("t6_fifth_stalled", tl_i_o.a_ready, 1'b0);
    next();
    idle();
    #1;
    drained("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
